// File: rtl/spi_cfg_receiver_pkg.sv
// rtl/spi_cfg_receiver_pkg.sv - shared types and constants for the SPI config receiver
package spi_cfg_receiver_pkg;

    localparam int SPI_STATUS_BITS = 16;

    typedef struct packed {
        logic [7:0] err_cnt;
        logic [7:0] frame_cnt;
    } spi_status_t;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } rx_state_e;

    localparam int NUM_OSC            = 16;
    localparam int ENVELOPE_RESET_BIT = 8;

    // env_reset sits at bit ENVELOPE_RESET_BIT of each oscillator word
    typedef struct packed {
        logic [31:0] phase_inc;
        logic [15:0] level;
        logic [6:0]  rsvd;
        logic        env_reset;
        logic [7:0]  wave_sel;
    } osc_cfg_t;

    typedef struct packed {
        osc_cfg_t [NUM_OSC-1:0] osc;
    } synth_t;

    localparam int OSC_BITS         = $bits(osc_cfg_t);
    localparam int SYNTH_FRAME_BITS = $bits(synth_t);

    function automatic logic [SYNTH_FRAME_BITS-1:0] synth_pulse_mask();
        logic [SYNTH_FRAME_BITS-1:0] m;
        m = '0;
        for (int o = 0; o < NUM_OSC; o++) begin
            m[o*OSC_BITS + ENVELOPE_RESET_BIT] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [SYNTH_FRAME_BITS-1:0] SYNTH_PULSE_MASK = synth_pulse_mask();

endpackage

// File: rtl/spi_cfg_receiver_pin_sync.sv
// rtl/spi_cfg_receiver_pin_sync.sv - synchronisers and registered edge strobes for the SPI pins
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic spi_csn,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_fall,
    output logic csn_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES:0]   settle_q;
    logic sclk_prev_q, csn_prev_q, armed_q;
    logic sclk_rise_q, sclk_fall_q, csn_fall_q, csn_rise_q, mosi_q;
    logic sclk_now, csn_now;

    assign sclk_now = sclk_sync_q[SYNC_STAGES-1];
    assign csn_now  = csn_sync_q[SYNC_STAGES-1];

    // csn_fall is only honoured once csn has been seen high after reset, so a
    // frame interrupted by reset cannot restart half way through
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
            settle_q    <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            csn_fall_q  <= 1'b0;
            csn_rise_q  <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            sclk_prev_q <= sclk_now;
            csn_prev_q  <= csn_now;
            armed_q     <= armed_q | (settle_q[SYNC_STAGES] & csn_now);
            sclk_rise_q <= sclk_now & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_now & sclk_prev_q;
            csn_fall_q  <= armed_q & csn_prev_q & ~csn_now;
            csn_rise_q  <= csn_now & ~csn_prev_q;
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_rise_q;
    assign sclk_fall = sclk_fall_q;
    assign csn_fall  = csn_fall_q;
    assign csn_rise  = csn_rise_q;
    assign mosi_s    = mosi_q;

endmodule

// File: rtl/spi_cfg_receiver.sv
// rtl/spi_cfg_receiver.sv - SPI slave receiving length-checked config frames, committed on sample_tick
module spi_cfg_receiver
    import spi_cfg_receiver_pkg::*;
#(
    parameter int                    FRAME_BITS  = SYNTH_FRAME_BITS,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [FRAME_BITS-1:0] PULSE_MASK  = '0,
    parameter logic [FRAME_BITS-1:0] CFG_RESET   = '0
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    input  logic                  spi_csn,
    output logic                  spi_miso,
    input  logic                  sample_tick,
    output logic [FRAME_BITS-1:0] cfg,
    output logic                  cfg_update,
    output logic                  frame_err,
    output logic [7:0]            frame_cnt,
    output logic [7:0]            err_cnt
);

    localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_csn   (spi_csn),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_fall  (csn_fall),
        .csn_rise  (csn_rise),
        .mosi_s    (mosi_s)
    );

    rx_state_e state_q, state_d;
    logic [FRAME_BITS-1:0]      rx_q, rx_d, staged_q, staged_d, cfg_q, cfg_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [SPI_STATUS_BITS-1:0] tx_q, tx_d;
    logic                       pending_q, pending_d, clr_armed_q, clr_armed_d;
    logic [7:0]                 frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic                       cfg_update_q, frame_err_q;
    logic start_frame, shift_rx, shift_tx, frame_ok, frame_bad, commit, pulse_clr;
    spi_status_t status;

    assign status = '{err_cnt: err_cnt_q, frame_cnt: frame_cnt_q};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (csn_fall) state_d = ST_RECV;
            ST_RECV: if (csn_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_frame = (state_q == ST_IDLE) && csn_fall;
        shift_rx    = (state_q == ST_RECV) && sclk_rise;
        shift_tx    = (state_q == ST_RECV) && sclk_fall;
        frame_ok    = (state_q == ST_RECV) && csn_rise && (bit_cnt_q == CNT_FULL);
        frame_bad   = (state_q == ST_RECV) && csn_rise && (bit_cnt_q != CNT_FULL);
        commit      = sample_tick && pending_q;
        pulse_clr   = sample_tick && clr_armed_q && !pending_q;
    end

    // commit takes the old staged value even when a new frame stages this cycle
    always_comb begin
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        staged_d    = staged_q;
        pending_d   = pending_q;
        clr_armed_d = clr_armed_q;
        cfg_d       = cfg_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (start_frame) begin
            bit_cnt_d = '0;
            tx_d      = status;
        end
        if (shift_rx) begin
            rx_d = {mosi_s, rx_q[FRAME_BITS-1:1]};
            if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (shift_tx) tx_d = {1'b0, tx_q[SPI_STATUS_BITS-1:1]};
        if (commit) begin
            cfg_d       = staged_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
            pending_d   = 1'b0;
            clr_armed_d = 1'b1;
        end else if (pulse_clr) begin
            cfg_d       = cfg_q & ~PULSE_MASK;
            clr_armed_d = 1'b0;
        end
        if (frame_ok) begin
            staged_d  = rx_q;
            pending_d = 1'b1;
        end
        if (frame_bad && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q         <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= '0;
            staged_q     <= '0;
            pending_q    <= 1'b0;
            clr_armed_q  <= 1'b0;
            cfg_q        <= CFG_RESET;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_q         <= rx_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            staged_q     <= staged_d;
            pending_q    <= pending_d;
            clr_armed_q  <= clr_armed_d;
            cfg_q        <= cfg_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            cfg_update_q <= commit;
            frame_err_q  <= frame_bad;
        end
    end

    assign spi_miso   = (state_q == ST_RECV) & tx_q[0];
    assign cfg        = cfg_q;
    assign cfg_update = cfg_update_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_spi_cfg_receiver.sv
// tb/tb_spi_cfg_receiver.sv - directed self-checking bench for spi_cfg_receiver
module tb_spi_cfg_receiver;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_miso;
    logic        sample_tick = 1'b0;
    logic [15:0] cfg;
    logic        cfg_update;
    logic        frame_err;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int upd_pulses = 0;
    int err_pulses = 0;
    logic [31:0] miso_word;

    spi_cfg_receiver #(
        .FRAME_BITS  (16),
        .SYNC_STAGES (2),
        .PULSE_MASK  (16'h0100),
        .CFG_RESET   (16'h0042)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_csn     (spi_csn),
        .spi_miso    (spi_miso),
        .sample_tick (sample_tick),
        .cfg         (cfg),
        .cfg_update  (cfg_update),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (cfg_update) upd_pulses++;
        if (frame_err)  err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_xfer(input logic [31:0] data, input int nbits, input bit do_start,
                            input bit do_end, output logic [31:0] miso);
        miso = '0;
        if (do_start) begin
            spi_csn = 1'b0;
            repeat (8) @(negedge sys_clk);
        end
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = data[i];
            repeat (8) @(negedge sys_clk);
            spi_clk = 1'b1;
            miso[i] = spi_miso;
            repeat (8) @(negedge sys_clk);
            spi_clk = 1'b0;
        end
        if (do_end) begin
            repeat (8) @(negedge sys_clk);
            spi_csn = 1'b1;
            repeat (16) @(negedge sys_clk);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        sample_tick = 1'b1;
        @(negedge sys_clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        repeat (4) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        chk("reset_cfg", 32'(cfg), 32'h0042);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("reset_err_cnt", 32'(err_cnt), 32'h0);
        chk("reset_miso", 32'(spi_miso), 32'h0);
        chk("reset_pulses", 32'(upd_pulses + err_pulses), 32'h0);

        spi_xfer(32'hA5C3, 16, 1'b1, 1'b1, miso_word);
        chk("first_status", miso_word, 32'h0000);
        chk("no_commit_before_tick", 32'(cfg), 32'h0042);
        tick();
        chk("valid_cfg", 32'(cfg), 32'hA5C3);
        chk("valid_frame_cnt", 32'(frame_cnt), 32'h1);
        chk("valid_upd_pulses", 32'(upd_pulses), 32'h1);
        chk("valid_no_err", 32'(err_pulses), 32'h0);

        spi_xfer(32'h01FF, 16, 1'b1, 1'b1, miso_word);
        tick();
        chk("cmd_commit", 32'(cfg), 32'h01FF);
        tick();
        chk("cmd_cleared", 32'(cfg), 32'h00FF);
        spi_xfer(32'h01FF, 16, 1'b1, 1'b1, miso_word);
        tick();
        spi_xfer(32'h0100, 16, 1'b1, 1'b1, miso_word);
        tick();
        chk("cmd_recommit", 32'(cfg), 32'h0100);
        tick();
        chk("cmd_recleared", 32'(cfg), 32'h0000);
        chk("cmd_frame_cnt", 32'(frame_cnt), 32'h4);

        spi_xfer(32'h1234, 15, 1'b1, 1'b1, miso_word);
        chk("short_status", miso_word, 32'h0004);
        spi_xfer(32'h1FFFF, 17, 1'b1, 1'b1, miso_word);
        chk("long_status", miso_word, 32'h0104);
        tick();
        chk("bad_err_pulses", 32'(err_pulses), 32'h2);
        chk("bad_err_cnt", 32'(err_cnt), 32'h2);
        chk("bad_cfg_unchanged", 32'(cfg), 32'h0000);
        chk("bad_no_update", 32'(upd_pulses), 32'h4);
        spi_xfer(32'h3C3C, 16, 1'b1, 1'b1, miso_word);
        tick();
        chk("after_bad_cfg", 32'(cfg), 32'h3C3C);
        chk("after_bad_frame_cnt", 32'(frame_cnt), 32'h5);

        spi_xfer(32'h1111, 16, 1'b1, 1'b1, miso_word);
        spi_xfer(32'h2222, 16, 1'b1, 1'b1, miso_word);
        tick();
        chk("overrun_cfg", 32'(cfg), 32'h2222);
        chk("overrun_frame_cnt", 32'(frame_cnt), 32'h6);
        chk("overrun_upd_pulses", 32'(upd_pulses), 32'h6);

        spi_xfer(32'h0F0F, 16, 1'b1, 1'b1, miso_word);
        chk("miso_status", miso_word, 32'h0206);
        chk("miso_idle_low", 32'(spi_miso), 32'h0);
        tick();
        chk("status_frame_cfg", 32'(cfg), 32'h0F0F);
        tick();
        chk("status_frame_clear", 32'(cfg), 32'h0E0F);

        spi_xfer(32'h00AB, 8, 1'b1, 1'b0, miso_word);
        @(negedge sys_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk("midreset_cfg", 32'(cfg), 32'h0042);
        chk("midreset_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("midreset_err_cnt", 32'(err_cnt), 32'h0);
        spi_xfer(32'h00CD, 8, 1'b0, 1'b1, miso_word);
        tick();
        chk("remainder_no_err", 32'(err_pulses), 32'h2);
        chk("remainder_err_cnt", 32'(err_cnt), 32'h0);
        chk("remainder_cfg", 32'(cfg), 32'h0042);
        spi_xfer(32'h7E81, 16, 1'b1, 1'b1, miso_word);
        tick();
        chk("post_reset_cfg", 32'(cfg), 32'h7E81);
        chk("post_reset_frame_cnt", 32'(frame_cnt), 32'h1);
        chk("post_reset_upd_pulses", 32'(upd_pulses), 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cfg_receiver.md
Name: spi_cfg_receiver

Overview:
Parametrised successor to the synth control unit: an SPI slave that receives fixed-length configuration frames from the MCU and publishes them as a flat config word to the synth datapath. All SPI pins are oversampled and synchronised into the single system clock, so no logic runs on spi_clk. Frames are length-checked and double-buffered. Commits are aligned to a sample-tick strobe. Self-clearing command bits are cleared in hardware after one tick, and a status word is returned on MISO.

Parameters:
FRAME_BITS, 1024, exact number of bits in a valid frame; config word width
SYNC_STAGES, 2, synchroniser depth on spi_clk/spi_mosi/spi_csn (>=2)
PULSE_MASK, '0 (FRAME_BITS wide), bits of cfg auto-cleared one sample tick after commit (e.g. envelope reset bits)
CFG_RESET, '0 (FRAME_BITS wide), value of cfg after reset

Ports:
sys_clk  in  1  system clock (18.432 MHz)
rst_n  in  1  reset, asynchronous assert, active-low
spi_clk  in  1  SPI clock from MCU, mode 0, async to sys_clk
spi_mosi  in  1  SPI data in, LSB-first
spi_csn  in  1  SPI chip select, active-low
spi_miso  out  1  status data out, LSB-first
sample_tick  in  1  one-cycle sys_clk strobe at 48 kHz
cfg  out  FRAME_BITS  committed configuration word
cfg_update  out  1  one-cycle pulse on each commit
frame_err  out  1  one-cycle pulse on each rejected frame
frame_cnt  out  8  count of accepted frames, wraps 255->0
err_cnt  out  8  count of rejected frames, saturates at 255

Behaviour:
- Reset is asynchronous and active-low. Values: cfg=CFG_RESET; counters 0; cfg_update=frame_err=0; spi_miso=0; state IDLE; csn synchroniser flops reset to 1, others to 0.
- Edge detect uses the last two synchronised samples. Sclk rise means sample; sclk fall means shift MISO. SPI clock high and low phases must each be >= SYNC_STAGES+2 sys_clk cycles.
- Receive FSM states:
  - IDLE: on csn fall, bit_cnt<=0, tx<={err_cnt,frame_cnt}, go to RECV.
  - RECV: on each sclk rise, rx<={mosi,rx[FRAME_BITS-1:1]}. bit_cnt saturates at FRAME_BITS+1. On csn rise, if bit_cnt==FRAME_BITS, staged<=rx and pending<=1; otherwise pulse frame_err and increment err_cnt (saturating). Either way, return to IDLE.
  - csn fall and rise within one cycle is impossible by the timing constraint. Edges seen in IDLE are ignored.
- The first bit sent lands in rx[0]. The frame image is identical to the MCU's struct, LSB-first.
- Commit: on sample_tick with pending=1, cfg<=staged, cfg_update=1, frame_cnt++, pending<=0, clr_armed<=1.
- Latency: csn rise at pin to pending=1 is SYNC_STAGES+2 cycles. Commit follows on the next sample_tick.
- Pulse clear: on sample_tick with clr_armed=1 and pending=0, cfg<=cfg&~PULSE_MASK and clr_armed<=0.
- Simultaneous pending and clr_armed on the same tick: commit wins and clr_armed stays 1. Command bits are therefore always visible for exactly one full tick period.
- Overrun: a second valid frame before the tick overwrites staged (latest wins). No counter increment. rx is independent of staged, so reception is never blocked.
- Same-cycle staging and tick: the tick commits the old staged value and the new frame stays pending.
- MISO: while csn is low, spi_miso=tx[0], and each sclk fall shifts tx right with 0 fill. spi_miso=0 while csn is high. Status is a 16-bit word; bits beyond 16 read 0.
- A rejected frame never alters staged, pending or cfg.
- Reset mid-frame discards rx and staged. Next frame needs a fresh csn fall after rst_n deasserts.

Decomposition:
- Add to protocol_pkg:
  - SPI_STATUS_BITS=16.
  - typedef spi_status_t {err_cnt, frame_cnt}.
  - localparam helper computing FRAME_BITS from $bits(synth_t).
  - PULSE_MASK built from ENVELOPE_RESET_BIT positions per oscillator.
- One sub-module, spi_pin_sync: synchronisers and edge detectors for the three pins. Outputs sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_s.
- Top level instantiates it with FRAME_BITS=$bits(synth_t) and casts cfg to synth_t.

Test Plan:
- Directed scenarios use FRAME_BITS=16, PULSE_MASK=16'h0100, sclk period 16 sys_clk.
- Valid frame 16'hA5C3 then sample_tick: cfg=16'hA5C3, cfg_update pulses once, frame_cnt=1, frame_err never asserts.
- Command bit clear: frame 16'h01FF, tick then second tick → cfg=16'h01FF after the first tick, 16'h00FF after the second. Repeat with a new frame 16'h0100 arriving before the second tick → cfg=16'h0100, cleared on the following tick.
- Short (15-bit) and long (17-bit) frames → two frame_err pulses, err_cnt=2, cfg unchanged; next 16-bit frame is accepted.
- Overrun: frames 16'h1111 then 16'h2222 before one tick → cfg=16'h2222, frame_cnt +1 only.
- MISO readback: after 3 valid and 1 rejected frame → next frame shifts out 16'h0103 LSB-first. spi_miso=0 with csn high.
- rst_n low for 3 cycles mid-frame → cfg=CFG_RESET, counters 0. Remainder of the interrupted frame is ignored; next complete frame is accepted.
